div_seq_ctrl: RTL and testbench
===============================

# div_seq_ctrl

Multi-cycle RV32M divide sequencer for the EX stage. Time-multiplexes one 32-bit ripple add/sub instance (SUB mode) to run restoring division plus sign fix-up, covering DIV/DIVU/REM/REMU. It holds the pipeline with `o_busy` for a fixed-latency computation and returns one result per accepted request.

## Interface
- Parameters: none. Width is fixed at 32 to match the shared adder.
- `i_clk`  in  1  — clock, all state updates on rising edge.
- `i_reset`  in  1  — asynchronous, active-high reset.
- `i_start`  in  1  — request valid; accepted only when `o_ready`=1.
- `i_op`  in  2  — 00 DIV, 01 DIVU, 10 REM, 11 REMU; latched on accept.
- `i_rs1`  in  32  — dividend; latched on accept.
- `i_rs2`  in  32  — divisor; latched on accept.
- `i_flush`  in  1  — abort current operation (branch or trap kill).
- `o_ready`  out  1  — idle and able to accept.
- `o_busy`  out  1  — operation in flight; drives the EX stall.
- `o_valid`  out  1  — one-cycle result strobe.
- `o_result`  out  32  — quotient or remainder; held until the next accept.

## Operation
- One internal add/sub instance, always `Sel`=1 (A−B).
  - NEG states: A=0, B=x.
  - CALC: A=shifted partial remainder, B=|divisor|.
- FSM: IDLE → NEG_A → NEG_B → CALC(32) → NEG_RES → DONE → IDLE.
- IDLE: `o_ready`=1, `o_busy`=0. Accept on `i_start` & !`i_flush`. Latch op, operands, sign_a, sign_b. sign_a=rs1[31] and sign_b=rs2[31] for DIV/REM; both 0 for unsigned ops.
- NEG_A: dividend register ← adder result if sign_a, else unchanged.
- NEG_B: divisor register ← adder result if sign_b, else unchanged.
- CALC (iteration counter 31→0), each cycle:
  - rs = {rem[30:0], dq[31]}; adder computes rs − dvs.
  - q bit = rem[31] | Carry_out. Carry_out=1 means no borrow.
  - If q bit=1: rem ← adder Y. Else rem ← rs.
  - dq ← {dq[30:0], q bit}.
- NEG_RES: select the result, then negate it if required.
  - Quotient (DIV/DIVU) is dq. Negate when sign_a^sign_b and divisor≠0.
  - Remainder (REM/REMU) is rem. Negate when sign_a.
  - Write `o_result`.
- DONE: `o_valid`=1 for exactly one cycle. `o_ready`=0, `o_busy`=0. Next state IDLE.
- Required special results:
  - Divide by zero: quotient=0xFFFFFFFF; remainder=dividend (signed and unsigned).
  - DIV 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- `i_start` outside IDLE: ignored, no queuing.
- `i_flush` in any non-IDLE state: next state IDLE. No `o_valid`; `o_result` unchanged.
- `i_flush` with `i_start` in IDLE: request not accepted.

## Timing
- Reset values: state=IDLE, `o_ready`=1, `o_busy`=0, `o_valid`=0, `o_result`=0. Internal registers and counter are 0.
- Reset mid-operation aborts immediately (async) with no `o_valid`.
- Accept on edge k. The FSM is then in:
  - NEG_A: cycle k+1.
  - NEG_B: cycle k+2.
  - CALC: cycles k+3..k+34.
  - NEG_RES: cycle k+35.
  - DONE: cycle k+36.
- `o_valid` is high during cycle k+36. Latency is fixed at 36 regardless of operands or signs.
- `o_busy` is high from cycle k+1 through k+35.
- `o_ready` returns high in cycle k+37. The earliest back-to-back accept is at edge k+37.
- `o_result` is registered and stable from cycle k+36 until the next accepted op reaches NEG_RES.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Test plan
- DIVU 100/7, then REMU 100/7 → `o_valid` at accept+36; results 0x0000000E, then 0x00000002. `o_busy` high exactly 35 cycles.
- Signed sign matrix, DIV and REM with (±7, ±2):
  - (−7, 2) → DIV 0xFFFFFFFD, REM 0xFFFFFFFF.
  - (7, −2) → DIV 0xFFFFFFFD, REM 0x00000001.
  - (−7, −2) → DIV 0x00000003, REM 0xFFFFFFFF.
- Divide by zero, rs1=0x80000005, rs2=0:
  - DIV and DIVU → 0xFFFFFFFF.
  - REM and REMU → 0x80000005.
- Overflow, DIV/REM 0x80000000 / 0xFFFFFFFF → 0x80000000 / 0x00000000.
- Flush and reset abort:
  - Flush at accept+10 → IDLE at accept+11, no `o_valid`, `o_result` keeps its prior value. New DIVU 0xFFFFFFFF/1 accepted next → 0xFFFFFFFF.
  - `i_reset` at accept+20 → all outputs at reset values immediately.
- `i_start` held high continuously with three queued ops:
  - Accepts land 37 cycles apart.
  - Starts during busy or DONE are ignored.
  - Exactly three `o_valid` pulses occur, each with the correct result.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: restoring division on one shared 32-bit subtractor, fixed 36-cycle latency.
// Accepts only in IDLE (o_ready); i_start elsewhere is dropped, i_flush aborts to IDLE without a result strobe.

module div_addsub (
    input  logic        sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        co
);
    // Ripple add/sub: sel=1 computes a - b, co=1 means no borrow.
    always_comb begin : rca
        logic c;
        logic bb;
        c  = sel;
        bb = 1'b0;
        y  = '0;
        for (int i = 0; i < 32; i++) begin
            bb   = b[i] ^ sel;
            y[i] = a[i] ^ bb ^ c;
            c    = (a[i] & bb) | (c & (a[i] ^ bb));
        end
        co = c;
    end
endmodule

module div_seq_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic        i_flush,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_result
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_NEG_A   = 3'd1;
    localparam logic [2:0] S_NEG_B   = 3'd2;
    localparam logic [2:0] S_CALC    = 3'd3;
    localparam logic [2:0] S_NEG_RES = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]  state;
    logic [1:0]  op_r;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] dq;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [4:0]  cnt;
    logic [31:0] result_r;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_y;
    logic        add_co;
    logic [31:0] rs;
    logic        q_bit;
    logic [31:0] res_sel;
    logic        neg_res;

    // op[1] selects remainder, op[0] marks the unsigned variants.
    assign rs      = {rem[30:0], dq[31]};
    assign q_bit   = rem[31] | add_co;
    assign res_sel = op_r[1] ? rem : dq;
    assign neg_res = op_r[1] ? sign_a : ((sign_a ^ sign_b) & (dvs != 32'd0));

    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            S_NEG_A:   add_b = dq;
            S_NEG_B:   add_b = dvs;
            S_CALC: begin
                add_a = rs;
                add_b = dvs;
            end
            S_NEG_RES: add_b = res_sel;
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    div_addsub u_addsub (
        .sel (1'b1),
        .a   (add_a),
        .b   (add_b),
        .y   (add_y),
        .co  (add_co)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_IDLE;
            op_r     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            dq       <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            result_r <= '0;
        end else if (state == S_IDLE) begin
            if (i_start && !i_flush) begin
                op_r   <= i_op;
                dq     <= i_rs1;
                dvs    <= i_rs2;
                rem    <= '0;
                sign_a <= !i_op[0] && i_rs1[31];
                sign_b <= !i_op[0] && i_rs2[31];
                state  <= S_NEG_A;
            end
        end else if (i_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_NEG_A: begin
                    if (sign_a) dq <= add_y;
                    state <= S_NEG_B;
                end
                S_NEG_B: begin
                    if (sign_b) dvs <= add_y;
                    cnt   <= 5'd31;
                    state <= S_CALC;
                end
                S_CALC: begin
                    rem <= q_bit ? add_y : rs;
                    dq  <= {dq[30:0], q_bit};
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) state <= S_NEG_RES;
                end
                S_NEG_RES: begin
                    result_r <= neg_res ? add_y : res_sel;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_ready  = (state == S_IDLE);
    assign o_busy   = (state == S_NEG_A) || (state == S_NEG_B) ||
                      (state == S_CALC)  || (state == S_NEG_RES);
    assign o_valid  = (state == S_DONE);
    assign o_result = result_r;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: scoreboard of expected results pushed on accept, popped on o_valid.
// Sampling happens 1ns after each rising edge; cycle numbering: the sample after edge e is cycle e+1.

module tb_div_seq_ctrl;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_flush;
    logic        o_ready;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;

    div_seq_ctrl dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_ready  (o_ready),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int n_valid  = 0;
    int busy_cnt = 0;
    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          acc_edges[$];
    logic [31:0] pend_exp = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic acc;
        int   a;
        acc = o_ready & i_start & ~i_flush & ~i_reset;
        @(posedge i_clk);
        #1;
        cyc++;
        if (acc) begin
            n_acc++;
            exp_q.push_back(pend_exp);
            acc_q.push_back(cyc);
            acc_edges.push_back(cyc);
            busy_cnt = 0;
        end
        if (o_busy) busy_cnt++;
        if (o_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("spurious_valid", {31'b0, o_valid}, 32'h0);
            end else begin
                check("result", o_result, exp_q.pop_front());
                a = acc_q.pop_front();
                check("latency", cyc + 1 - a, 32'd36);
                check("busy_cycles", busy_cnt, 32'd35);
                check("ready_in_done", {31'b0, o_ready}, 32'h0);
                check("busy_in_done", {31'b0, o_busy}, 32'h0);
            end
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int start_acc;
        int n;
        start_acc = n_acc;
        i_op      = op;
        i_rs1     = a;
        i_rs2     = b;
        pend_exp  = exp;
        i_start   = 1'b1;
        n = 0;
        while (n_acc == start_acc && n < 50) begin
            tick();
            n++;
        end
        i_start = 1'b0;
        check("accepted", n_acc - start_acc, 32'd1);
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check("completed", exp_q.size(), 32'd0);
        exp_q.delete();
        acc_q.delete();
        tick();
    endtask

    task automatic start_and_wait_accept(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        int start_acc;
        int n;
        start_acc = n_acc;
        i_op  = op;
        i_rs1 = a;
        i_rs2 = b;
        i_start = 1'b1;
        n = 0;
        while (n_acc == start_acc && n < 50) begin
            tick();
            n++;
        end
        i_start = 1'b0;
        check("abort_op_accepted", n_acc - start_acc, 32'd1);
    endtask

    initial begin
        int          a0;
        int          nv;
        int          e0;
        int          seen;
        int          n;
        logic [1:0]  hop[3];
        logic [31:0] ha[3];
        logic [31:0] hb[3];
        logic [31:0] he[3];

        i_reset = 1'b1;
        i_start = 1'b0;
        i_flush = 1'b0;
        i_op    = '0;
        i_rs1   = '0;
        i_rs2   = '0;
        #12;
        check("reset_ready",  {31'b0, o_ready}, 32'h1);
        check("reset_busy",   {31'b0, o_busy},  32'h0);
        check("reset_valid",  {31'b0, o_valid}, 32'h0);
        check("reset_result", o_result,         32'h0);
        i_reset = 1'b0;
        tick();
        tick();

        run_op(OP_DIVU, 32'd100, 32'd7, 32'h0000000E);
        run_op(OP_REMU, 32'd100, 32'd7, 32'h00000002);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        run_op(OP_REM, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        run_op(OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD);
        run_op(OP_REM, 32'h00000007, 32'hFFFFFFFE, 32'h00000001);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003);
        run_op(OP_REM, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF);

        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

        run_op(OP_DIV,  32'h80000005, 32'h0, 32'hFFFFFFFF);
        run_op(OP_DIVU, 32'h80000005, 32'h0, 32'hFFFFFFFF);
        run_op(OP_REM,  32'h80000005, 32'h0, 32'h80000005);
        run_op(OP_REMU, 32'h80000005, 32'h0, 32'h80000005);

        // Flush at accept+10: the aborted op must never strobe o_valid.
        pend_exp = 32'd333;
        start_and_wait_accept(OP_DIVU, 32'd1000, 32'd3);
        a0 = acc_edges[$];
        n = 0;
        while (cyc < a0 + 9 && n < 20) begin
            tick();
            n++;
        end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        if (acc_q.size() != 0) void'(acc_q.pop_back());
        check("flush_ready", {31'b0, o_ready}, 32'h1);
        check("flush_busy",  {31'b0, o_busy},  32'h0);
        nv = n_valid;
        repeat (40) tick();
        check("flush_no_valid", n_valid - nv, 32'd0);
        check("flush_result_held", o_result, 32'h80000005);
        run_op(OP_DIVU, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF);

        // Async reset at accept+20, applied mid-cycle.
        pend_exp = 32'hFFFFFFF2;
        start_and_wait_accept(OP_DIV, 32'hFFFFFF9C, 32'd7);
        a0 = acc_edges[$];
        n = 0;
        while (cyc < a0 + 19 && n < 30) begin
            tick();
            n++;
        end
        #2;
        i_reset = 1'b1;
        #1;
        check("arst_ready",  {31'b0, o_ready}, 32'h1);
        check("arst_busy",   {31'b0, o_busy},  32'h0);
        check("arst_valid",  {31'b0, o_valid}, 32'h0);
        check("arst_result", o_result,         32'h0);
        exp_q.delete();
        acc_q.delete();
        tick();
        i_reset = 1'b0;
        nv = n_valid;
        repeat (40) tick();
        check("arst_no_valid", n_valid - nv, 32'd0);

        // i_start held high across three back-to-back operations.
        hop[0] = OP_DIV;  ha[0] = 32'hFFFFFF9C; hb[0] = 32'd7;     he[0] = 32'hFFFFFFF2;
        hop[1] = OP_REM;  ha[1] = 32'hFFFFFF9C; hb[1] = 32'd7;     he[1] = 32'hFFFFFFFE;
        hop[2] = OP_DIVU; ha[2] = 32'hFFFFFFFF; hb[2] = 32'h10;    he[2] = 32'h0FFFFFFF;
        nv   = n_valid;
        e0   = acc_edges.size();
        seen = 0;
        i_op = hop[0]; i_rs1 = ha[0]; i_rs2 = hb[0]; pend_exp = he[0];
        i_start = 1'b1;
        n = 0;
        while (n_valid - nv < 3 && n < 200) begin
            tick();
            n++;
            if (acc_edges.size() - e0 != seen) begin
                seen = acc_edges.size() - e0;
                if (seen < 3) begin
                    i_op = hop[seen]; i_rs1 = ha[seen]; i_rs2 = hb[seen]; pend_exp = he[seen];
                end
            end
        end
        i_start = 1'b0;
        repeat (5) tick();
        check("held_valid_count", n_valid - nv, 32'd3);
        check("held_accept_count", acc_edges.size() - e0, 32'd3);
        if (acc_edges.size() - e0 >= 3) begin
            check("held_gap1", acc_edges[e0+1] - acc_edges[e0],   32'd37);
            check("held_gap2", acc_edges[e0+2] - acc_edges[e0+1], 32'd37);
        end
        check("held_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
